// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path.
// Holds the FSM state codes, the ALU operation codes, the base opcodes
// recognised by the decoder and the datapath mux select encodings.
// The control FSM, the ALU-op decoder and the ALU import this package.
package rv_ctrl_pkg;

  // FSM state codes, also exported on state_dbg
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_R    = 4'd3;
  localparam logic [3:0] S_EXEC_I    = 4'd4;
  localparam logic [3:0] S_MEM_ADDR  = 4'd5;
  localparam logic [3:0] S_MEM_RD    = 4'd6;
  localparam logic [3:0] S_MEM_WB    = 4'd7;
  localparam logic [3:0] S_MEM_WR    = 4'd8;
  localparam logic [3:0] S_ALU_WB    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JALR_ADDR = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // RV32I base opcodes handled by this core
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Register-file write data select
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode for the execute states.
// Ports:
//   opcode    in  7  instruction opcode
//   funct3    in  3  instruction funct3
//   funct7_b5 in  1  instruction bit 30
//   alu_op    out 4  ALU operation code
module alu_op_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_op
);

  logic is_arith;

  // Only R-type and OP-IMM carry an operation in funct3; everything else adds
  assign is_arith = (opcode == OP_R) || (opcode == OP_IMM);

  always_comb begin
    alu_op = ALU_ADD;
    if (is_arith) begin
      case (funct3)
        // bit 30 is part of the immediate for ADDI, so SUB is R-type only
        3'b000:  alu_op = (funct7_b5 && opcode == OP_R) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the memory handshake, write enables, ALU operand selects and ALU op.
// Unsupported opcodes park the core in TRAP until reset.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   opcode, funct3, funct7_b5    decoder fields of the instruction in IR
//   br_taken                     branch comparator result
//   mem_ready                    memory accepts/completes the request
//   mem_req, mem_we, addr_src    memory request, write, address select
//   ir_write, old_pc_write,
//   pc_write, reg_write          write enables
//   pc_src                       PC source (0 ALU result, 1 ALUOut)
//   alu_src_a, alu_src_b, alu_op ALU operand selects and operation
//   result_src                   register write data select
//   illegal                      sticky unsupported-opcode flag
//   state_dbg                    current state code
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter bit RESET_TO_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       old_pc_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] RST_STATE = RESET_TO_IDLE ? S_IDLE : S_FETCH;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] dec_alu_op;

  alu_op_decode u_alu_op_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .alu_op    (dec_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:                     state_nxt = S_EXEC_R;
          OP_IMM, OP_LUI, OP_AUIPC: state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:        state_nxt = S_MEM_ADDR;
          OP_BRANCH:                state_nxt = S_BRANCH;
          OP_JAL:                   state_nxt = S_JUMP;
          OP_JALR:                  state_nxt = S_JALR_ADDR;
          default:                  state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
      S_MEM_ADDR: state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_JALR_ADDR: state_nxt = S_JUMP;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_TRAP;
    endcase
  end

  // Outputs follow the state register; only the FETCH enables and the
  // BRANCH pc_write look at mem_ready/br_taken. Everything is forced low
  // while reset is held so a reset-to-FETCH build issues no request then.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_src     = 1'b0;
    ir_write     = 1'b0;
    old_pc_write = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    result_src   = RES_ALUOUT;
    illegal      = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          alu_src_b    = SRCB_FOUR;
          ir_write     = mem_ready;
          old_pc_write = mem_ready;
          pc_write     = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = dec_alu_op;
        end
        S_EXEC_I: begin
          alu_src_b = SRCB_IMM;
          alu_op    = dec_alu_op;
          if (opcode == OP_LUI)        alu_src_a = SRCA_ZERO;
          else if (opcode == OP_AUIPC) alu_src_a = SRCA_OLDPC;
          else                         alu_src_a = SRCA_RS1;
        end
        S_MEM_ADDR, S_JALR_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_ALU_WB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
        end
        S_BRANCH: begin
          pc_src   = 1'b1;
          pc_write = br_taken;
        end
        S_JUMP: begin
          pc_src     = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          reg_write  = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks hand-picked instructions
// through the FSM and compares every control output of interest.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_src;
  logic       ir_write, old_pc_write, pc_write, reg_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_op;
  logic       illegal;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam int IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, EXEC_I = 4,
                 MEM_ADDR = 5, MEM_RD = 6, MEM_WB = 7, MEM_WR = 8,
                 ALU_WB = 9, BRANCH = 10, JALR_ADDR = 11, JUMP = 12, TRAP = 13;

  multicycle_control #(.RESET_TO_IDLE(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7_b5    (funct7_b5),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_src     (addr_src),
    .ir_write     (ir_write),
    .old_pc_write (old_pc_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .illegal      (illegal),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge, then check the state
  task automatic step(input int exp_state);
    @(posedge clk);
    #1;
    chk("state", int'(state_dbg), exp_state);
  endtask

  // In FETCH with zero-wait memory: present the next instruction fields,
  // check the fetch controls, move to DECODE and check its ALU setup.
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic b5);
    opcode = op; funct3 = f3; funct7_b5 = b5; mem_ready = 1'b1;
    #1;
    chk("fetch_req", int'(mem_req), 1);
    chk("fetch_irw", int'(ir_write), 1);
    chk("fetch_pcw", int'(pc_write), 1);
    chk("fetch_srcb", int'(alu_src_b), 2);
    step(DECODE);
    chk("dec_srca", int'(alu_src_a), 1);
    chk("dec_srcb", int'(alu_src_b), 1);
    chk("dec_regw", int'(reg_write), 0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'h13; funct3 = 3'd0; funct7_b5 = 1'b0;
    br_taken = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state_dbg), IDLE);
    chk("rst_req", int'(mem_req), 0);
    chk("rst_illegal", int'(illegal), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", int'(mem_req), 0);
    chk("idle_irw", int'(ir_write), 0);
    step(FETCH);

    // addi x1,x0,5: IDLE, FETCH, DECODE, EXEC_I, ALU_WB
    fetch(7'b0010011, 3'b000, 1'b0);
    step(EXEC_I);
    chk("addi_srca", int'(alu_src_a), 2);
    chk("addi_srcb", int'(alu_src_b), 1);
    chk("addi_op", int'(alu_op), 0);
    chk("addi_regw_early", int'(reg_write), 0);
    step(ALU_WB);
    chk("addi_regw", int'(reg_write), 1);
    chk("addi_res", int'(result_src), 0);
    step(FETCH);

    // FETCH stalled for 3 cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_req", int'(mem_req), 1);
      chk("wait_addr", int'(addr_src), 0);
      chk("wait_irw", int'(ir_write), 0);
      chk("wait_pcw", int'(pc_write), 0);
      step(FETCH);
    end

    // sub: R-type, funct3 000, bit30 set
    fetch(7'b0110011, 3'b000, 1'b1);
    step(EXEC_R);
    chk("sub_op", int'(alu_op), 1);
    chk("sub_srca", int'(alu_src_a), 2);
    chk("sub_srcb", int'(alu_src_b), 0);
    step(ALU_WB);
    step(FETCH);

    // srai
    fetch(7'b0010011, 3'b101, 1'b1);
    step(EXEC_I);
    chk("srai_op", int'(alu_op), 7);
    step(ALU_WB);
    step(FETCH);

    // addi with imm bit 10 set must still add
    fetch(7'b0010011, 3'b000, 1'b1);
    step(EXEC_I);
    chk("addi_b5_op", int'(alu_op), 0);
    step(ALU_WB);
    step(FETCH);

    // R-type and
    fetch(7'b0110011, 3'b111, 1'b0);
    step(EXEC_R);
    chk("and_op", int'(alu_op), 9);
    step(ALU_WB);
    step(FETCH);

    // lui: zero + imm
    fetch(7'b0110111, 3'b101, 1'b1);
    step(EXEC_I);
    chk("lui_srca", int'(alu_src_a), 3);
    chk("lui_op", int'(alu_op), 0);
    step(ALU_WB);
    step(FETCH);

    // auipc: oldPC + imm
    fetch(7'b0010111, 3'b000, 1'b0);
    step(EXEC_I);
    chk("auipc_srca", int'(alu_src_a), 1);
    step(ALU_WB);
    step(FETCH);

    // lw, one wait state on the read
    fetch(7'b0000011, 3'b010, 1'b0);
    step(MEM_ADDR);
    chk("lw_srca", int'(alu_src_a), 2);
    chk("lw_srcb", int'(alu_src_b), 1);
    mem_ready = 1'b0;
    step(MEM_RD);
    chk("lw_req", int'(mem_req), 1);
    chk("lw_addr", int'(addr_src), 1);
    chk("lw_we", int'(mem_we), 0);
    step(MEM_RD);
    chk("lw_req_held", int'(mem_req), 1);
    mem_ready = 1'b1;
    step(MEM_WB);
    chk("lw_res", int'(result_src), 1);
    chk("lw_regw", int'(reg_write), 1);
    step(FETCH);

    // sw
    fetch(7'b0100011, 3'b010, 1'b0);
    step(MEM_ADDR);
    step(MEM_WR);
    chk("sw_we", int'(mem_we), 1);
    chk("sw_addr", int'(addr_src), 1);
    chk("sw_req", int'(mem_req), 1);
    chk("sw_regw", int'(reg_write), 0);
    step(FETCH);

    // beq not taken, then taken
    fetch(7'b1100011, 3'b000, 1'b0);
    br_taken = 1'b0;
    step(BRANCH);
    chk("beq_nt_pcw", int'(pc_write), 0);
    chk("beq_pcsrc", int'(pc_src), 1);
    step(FETCH);
    fetch(7'b1100011, 3'b000, 1'b0);
    br_taken = 1'b1;
    step(BRANCH);
    chk("beq_t_pcw", int'(pc_write), 1);
    chk("beq_t_regw", int'(reg_write), 0);
    step(FETCH);
    br_taken = 1'b0;

    // jal
    fetch(7'b1101111, 3'b000, 1'b0);
    step(JUMP);
    chk("jal_pcw", int'(pc_write), 1);
    chk("jal_regw", int'(reg_write), 1);
    chk("jal_res", int'(result_src), 2);
    chk("jal_srca", int'(alu_src_a), 1);
    chk("jal_srcb", int'(alu_src_b), 2);
    chk("jal_pcsrc", int'(pc_src), 1);
    step(FETCH);

    // jalr
    fetch(7'b1100111, 3'b000, 1'b0);
    step(JALR_ADDR);
    chk("jalr_srca", int'(alu_src_a), 2);
    chk("jalr_srcb", int'(alu_src_b), 1);
    chk("jalr_pcw_early", int'(pc_write), 0);
    step(JUMP);
    step(FETCH);

    // unsupported opcode traps and stays
    fetch(7'h7F, 3'b000, 1'b0);
    step(TRAP);
    chk("trap_illegal", int'(illegal), 1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      step(TRAP);
      chk("trap_req", int'(mem_req), 0);
      chk("trap_illegal_hold", int'(illegal), 1);
    end
    rst_n = 1'b0;
    #1;
    chk("trap_rst_illegal", int'(illegal), 0);
    chk("trap_rst_state", int'(state_dbg), IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    step(FETCH);

    // reset mid-fetch-wait: request dropped, no write enable
    #1;
    chk("midwait_req", int'(mem_req), 1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("midrst_req", int'(mem_req), 0);
    chk("midrst_irw", int'(ir_write), 0);
    chk("midrst_pcw", int'(pc_write), 0);
    chk("midrst_state", int'(state_dbg), IDLE);
    @(posedge clk);
    #1;
    chk("midrst_hold", int'(state_dbg), IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM that sequences the multicycle RV32I datapath around the instruction decoder. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the memory handshake, register/PC/IR write enables, ALU operand selects and ALU operation from the decoder's opcode/funct fields. Unsupported opcodes stop the core in a sticky trap state.

## Interface
Parameters:
- `RESET_TO_IDLE`, 1: reset enters IDLE (all controls low) for one cycle before the first FETCH.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instr[6:0] from decoder, valid while IR is stable.
- `funct3`  in  3  instr[14:12].
- `funct7_b5`  in  1  instr[30].
- `br_taken`  in  1  branch comparator result for rs1/rs2 under funct3.
- `mem_ready`  in  1  memory accepts/completes the current request.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  write (store) request.
- `addr_src`  out  1  0 = PC, 1 = ALUOut.
- `ir_write`, `old_pc_write`, `pc_write`, `reg_write`  out  1 each  write enables.
- `pc_src`  out  1  0 = ALU result, 1 = ALUOut.
- `alu_src_a`  out  2  0 = PC, 1 = oldPC, 2 = rs1, 3 = zero.
- `alu_src_b`  out  2  0 = rs2, 1 = imm_ext, 2 = constant 4.
- `alu_op`  out  4  ALU operation code.
- `result_src`  out  2  0 = ALUOut, 1 = memory read data, 2 = ALU result.
- `illegal`  out  1  sticky unsupported-opcode flag.
- `state_dbg`  out  4  current state encoding.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JALR_ADDR, JUMP, TRAP.
- FETCH:
  - Drives mem_req=1, addr_src=0, alu_src_a=0, alu_src_b=2, ADD.
  - On mem_ready: ir_write, old_pc_write, pc_write (PC+4) and go to DECODE. Otherwise stay.
- DECODE: ALUOut ← oldPC + imm (branch/JAL target), with alu_src_a=1, alu_src_b=1, ADD. Next state by opcode:
  - 0110011 → EXEC_R.
  - 0010011, 0110111, 0010111 → EXEC_I.
  - 0000011, 0100011 → MEM_ADDR.
  - 1100011 → BRANCH.
  - 1101111 → JUMP.
  - 1100111 → JALR_ADDR.
  - anything else → TRAP.
- EXEC_R / EXEC_I → ALU_WB.
  - EXEC_R: a=rs1, b=rs2.
  - EXEC_I: b=imm. a=rs1 (OP-IMM), zero (LUI), oldPC (AUIPC).
  - alu_op from funct3. funct7_b5 selects SUB (R-type only) and SRA/SRAI. LUI/AUIPC use ADD.
- ALU_WB: result_src=0, reg_write=1 → FETCH.
- MEM_ADDR: ALUOut ← rs1+imm. Load → MEM_RD, store → MEM_WR.
- MEM_RD: mem_req=1, addr_src=1. On mem_ready → MEM_WB.
- MEM_WB: result_src=1, reg_write=1 → FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_src=1. On mem_ready → FETCH.
- BRANCH: pc_src=1, pc_write=br_taken → FETCH.
- JALR_ADDR: ALUOut ← rs1+imm. The datapath clears bit 0 → JUMP.
- JUMP:
  - pc_src=1, pc_write=1.
  - ALU computes oldPC+4 (a=1, b=2); result_src=2, reg_write=1.
  - → FETCH.
- TRAP: illegal=1, all enables and mem_req 0. Left only by reset.
- alu_op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- Unlisted control outputs are 0 in every state.

## Timing
- Reset:
  - rst_n low → state IDLE (or FETCH if RESET_TO_IDLE=0) immediately.
  - All outputs 0 and illegal cleared while rst_n is low.
  - First mem_req is asserted the cycle after IDLE.
- All outputs are decoded from the state register only (Moore). The next-state logic may use mem_ready/br_taken.
- Enables that depend on mem_ready (FETCH ir_write/pc_write) are qualified combinationally with mem_ready.
- Handshake: mem_req, mem_we and addr_src stay stable until a cycle with mem_ready=1. Zero-wait memory (mem_ready tied high) is legal.
- Minimum cycles per instruction with zero-wait memory:
  - branch 3.
  - R/I/LUI/AUIPC 4.
  - store 4.
  - load 5.
  - JAL 3, JALR 4.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-wait abandons the request with no write enable pulsed.

## Structure
- Package `rv_ctrl_pkg`: state enum, alu_op codes, opcode constants, and the alu_src_a/alu_src_b/result_src encodings. The decoder and ALU import it.
- One sub-module, `alu_op_decode`: combinational (opcode, funct3, funct7_b5) → alu_op.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready=1:
  - states IDLE, FETCH, DECODE, EXEC_I, ALU_WB.
  - reg_write pulses in cycle 5, alu_src_b=1, alu_op=0.
- FETCH with mem_ready low for 3 cycles: mem_req/addr_src held; ir_write and pc_write stay 0 until the ready cycle.
- sub (funct7_b5=1, funct3=000, R-type) → alu_op=1. srai (opcode 0010011, funct3=101, b5=1) → alu_op=7.
- lw then sw:
  - lw visits MEM_RD → MEM_WB with result_src=1.
  - sw asserts mem_we=1 and addr_src=1; no reg_write.
- beq with br_taken=0, then 1: pc_write is 0, then 1 in BRANCH. JAL: pc_write=1, reg_write=1, result_src=2.
- Opcode 0x7F: TRAP, illegal=1, mem_req stays 0 for 20 cycles. rst_n low clears illegal asynchronously.
